pll_rst_seq: RTL and testbench

Reset sequencer directly downstream of the board PLL wrapper. It samples the PLL `locked` flag, requires lock to stay stable for a programmable interval, then releases three reset domains in a fixed order: memory, then video, then core. Any loss of lock re-asserts every reset. It runs on the 50 MHz board reference clock, never on a PLL output, so it keeps operating while the PLL is unlocked.

---
 rtl/pll_rst_seq_pkg.sv | 20 ++
 rtl/sync_ff2.sv | 22 ++
 rtl/pll_rst_seq.sv | 170 +++++++++++++++++
 tb/tb_pll_rst_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_rst_seq_pkg.sv
// Shared types and default count constants for the PLL reset sequencer.
package pll_rst_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        REL_MEM   = 3'd2,
        REL_VID   = 3'd3,
        RUN       = 3'd4,
        PLL_RST   = 3'd5
    } state_t;

    localparam int unsigned DEF_CNT_W          = 20;
    localparam int unsigned DEF_LOCK_CYCLES    = 1000;
    localparam int unsigned DEF_STAGE_GAP      = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT   = 500000;
    localparam int unsigned DEF_PLL_RST_CYCLES = 8;
    localparam int unsigned RELOCK_W           = 4;

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 under reset.
module sync_ff2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_rst_seq.sv
// Reset sequencer behind the board PLL: waits for stable lock, then releases
// memory, video and core resets in order; any lock loss re-asserts them all.
// Optional macro PLL_RST_SEQ_RELOCK_EN adds a timed PLL reset retry when lock
// never arrives, counted on relock_cnt.
module pll_rst_seq
    import pll_rst_seq_pkg::*;
#(
    parameter int unsigned CNT_W          = DEF_CNT_W,
    parameter int unsigned LOCK_CYCLES    = DEF_LOCK_CYCLES,
    parameter int unsigned STAGE_GAP      = DEF_STAGE_GAP,
    parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       locked,
    output logic       pll_rst,
    output logic       mem_rst_n,
    output logic       vid_rst_n,
    output logic       core_rst_n,
    output logic       ready,
    output logic [3:0] relock_cnt
);

    // Every count must fit the shared counter so no terminal compare is missed.
    localparam bit PARAMS_OK = (LOCK_CYCLES >= 1) && (STAGE_GAP >= 1) &&
                               (PLL_RST_CYCLES >= 1) && (LOCK_TIMEOUT >= 1) &&
                               (CNT_W >= 1) && (CNT_W <= 31) &&
                               ((LOCK_CYCLES >> CNT_W) == 0) &&
                               ((STAGE_GAP >> CNT_W) == 0) &&
                               ((LOCK_TIMEOUT >> CNT_W) == 0) &&
                               ((PLL_RST_CYCLES >> CNT_W) == 0);

    generate
        if (!PARAMS_OK) begin : g_param_err
            $error("pll_rst_seq: count parameters out of range for CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LOCK_TERM = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(STAGE_GAP - 1);
`ifdef PLL_RST_SEQ_RELOCK_EN
    localparam logic [CNT_W-1:0] TIMEOUT_TERM = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PRST_TERM    = CNT_W'(PLL_RST_CYCLES - 1);
`endif

    logic                locked_s;
    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                pll_rst_nxt, mem_nxt, vid_nxt, core_nxt, ready_nxt;
    logic [RELOCK_W-1:0] relock_nxt;

    sync_ff2 u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (locked),
        .q     (locked_s)
    );

    // State and shared counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and counter logic; lock loss overrides any terminal count.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        case (state)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else begin
`ifdef PLL_RST_SEQ_RELOCK_EN
                    if (cnt == TIMEOUT_TERM) begin
                        state_nxt = PLL_RST;
                        cnt_nxt   = '0;
                    end
`else
                    cnt_nxt = cnt;
`endif
                end
            end
            STABLE: begin
                if (cnt == LOCK_TERM) begin
                    state_nxt = REL_MEM;
                    cnt_nxt   = '0;
                end
            end
            REL_MEM: begin
                if (cnt == GAP_TERM) begin
                    state_nxt = REL_VID;
                    cnt_nxt   = '0;
                end
            end
            REL_VID: begin
                if (cnt == GAP_TERM) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                cnt_nxt = cnt;
            end
            PLL_RST: begin
`ifdef PLL_RST_SEQ_RELOCK_EN
                if (cnt == PRST_TERM) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end
`else
                state_nxt = WAIT_LOCK;
                cnt_nxt   = '0;
`endif
            end
            default: begin
                state_nxt = WAIT_LOCK;
                cnt_nxt   = '0;
            end
        endcase
        if (!locked_s && (state != WAIT_LOCK) && (state != PLL_RST)) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
        end
    end

    // Output values for the next edge, decoded from the next state.
    always_comb begin
        pll_rst_nxt = 1'b0;
        relock_nxt  = '0;
        mem_nxt     = (state_nxt == REL_MEM) || (state_nxt == REL_VID) || (state_nxt == RUN);
        vid_nxt     = (state_nxt == REL_VID) || (state_nxt == RUN);
        core_nxt    = (state_nxt == RUN);
        ready_nxt   = (state_nxt == RUN);
`ifdef PLL_RST_SEQ_RELOCK_EN
        pll_rst_nxt = (state_nxt == PLL_RST);
        relock_nxt  = relock_cnt;
        if ((state == PLL_RST) && (state_nxt == WAIT_LOCK) && (relock_cnt != 4'hF)) begin
            relock_nxt = relock_cnt + 4'd1;
        end
`endif
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pll_rst    <= 1'b1;
            mem_rst_n  <= 1'b0;
            vid_rst_n  <= 1'b0;
            core_rst_n <= 1'b0;
            ready      <= 1'b0;
            relock_cnt <= '0;
        end else begin
            pll_rst    <= pll_rst_nxt;
            mem_rst_n  <= mem_nxt;
            vid_rst_n  <= vid_nxt;
            core_rst_n <= core_nxt;
            ready      <= ready_nxt;
            relock_cnt <= relock_nxt;
        end
    end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq with LOCK_CYCLES=4, STAGE_GAP=2,
// LOCK_TIMEOUT=10, PLL_RST_CYCLES=3. Relock checks follow PLL_RST_SEQ_RELOCK_EN.
module tb_pll_rst_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       locked = 1'b0;
    logic       pll_rst;
    logic       mem_rst_n;
    logic       vid_rst_n;
    logic       core_rst_n;
    logic       ready;
    logic [3:0] relock_cnt;

    int tests = 0;
    int fails = 0;

    pll_rst_seq #(
        .CNT_W          (8),
        .LOCK_CYCLES    (4),
        .STAGE_GAP      (2),
        .LOCK_TIMEOUT   (10),
        .PLL_RST_CYCLES (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .locked     (locked),
        .pll_rst    (pll_rst),
        .mem_rst_n  (mem_rst_n),
        .vid_rst_n  (vid_rst_n),
        .core_rst_n (core_rst_n),
        .ready      (ready),
        .relock_cnt (relock_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        locked = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if ({pll_rst, mem_rst_n, vid_rst_n, core_rst_n, ready} !== 5'b10000) begin
                fails++;
                $display("FAIL reset_hold cyc=%0d got {pll,mem,vid,core,rdy}=%b exp 10000", i,
                         {pll_rst, mem_rst_n, vid_rst_n, core_rst_n, ready});
            end
        end
        rst_n  = 1'b1;
        locked = 1'b0;
        tick();
        tests++;
        if (pll_rst !== 1'b0) begin
            fails++;
            $display("FAIL reset_release pll_rst got %b exp 0", pll_rst);
        end
        tests++;
        if (relock_cnt !== 4'd0) begin
            fails++;
            $display("FAIL reset_relock_cnt got %0d exp 0", relock_cnt);
        end
    endtask

    // Raise locked from WAIT_LOCK and check mem/vid/core at k+6/k+8/k+10.
    task automatic test_release(input string tag);
        logic exp_mem, exp_vid, exp_core;
        locked = 1'b1;
        tick();
        tests++;
        if ({mem_rst_n, vid_rst_n, core_rst_n, ready} !== 4'b0000) begin
            fails++;
            $display("FAIL %s e=0 got {mem,vid,core,rdy}=%b exp 0000", tag,
                     {mem_rst_n, vid_rst_n, core_rst_n, ready});
        end
        for (int e = 1; e <= 11; e++) begin
            tick();
            exp_mem  = (e >= 6);
            exp_vid  = (e >= 8);
            exp_core = (e >= 10);
            tests++;
            if (mem_rst_n !== exp_mem) begin
                fails++;
                $display("FAIL %s mem_rst_n e=%0d got %b exp %b", tag, e, mem_rst_n, exp_mem);
            end
            tests++;
            if (vid_rst_n !== exp_vid) begin
                fails++;
                $display("FAIL %s vid_rst_n e=%0d got %b exp %b", tag, e, vid_rst_n, exp_vid);
            end
            tests++;
            if ({core_rst_n, ready} !== {exp_core, exp_core}) begin
                fails++;
                $display("FAIL %s core/ready e=%0d got %b%b exp %b%b", tag, e,
                         core_rst_n, ready, exp_core, exp_core);
            end
            tests++;
            if (pll_rst !== 1'b0) begin
                fails++;
                $display("FAIL %s pll_rst e=%0d got %b exp 0", tag, e, pll_rst);
            end
        end
    endtask

    task automatic test_loss_in_run();
        locked = 1'b0;
        tick();
        tick();
        tests++;
        if ({mem_rst_n, vid_rst_n, core_rst_n, ready} !== 4'b1111) begin
            fails++;
            $display("FAIL loss_j1 got {mem,vid,core,rdy}=%b exp 1111",
                     {mem_rst_n, vid_rst_n, core_rst_n, ready});
        end
        tick();
        tests++;
        if ({mem_rst_n, vid_rst_n, core_rst_n, ready} !== 4'b0000) begin
            fails++;
            $display("FAIL loss_j2 got {mem,vid,core,rdy}=%b exp 0000",
                     {mem_rst_n, vid_rst_n, core_rst_n, ready});
        end
        test_release("release_after_loss");
    endtask

    task automatic test_unstable_lock();
        locked = 1'b0;
        repeat (3) tick();
        locked = 1'b1;
        repeat (3) tick();
        locked = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests++;
            if ({mem_rst_n, vid_rst_n, core_rst_n, ready} !== 4'b0000) begin
                fails++;
                $display("FAIL unstable cyc=%0d got {mem,vid,core,rdy}=%b exp 0000", i,
                         {mem_rst_n, vid_rst_n, core_rst_n, ready});
            end
        end
        test_release("release_after_unstable");
    endtask

    task automatic test_reset_in_rel_vid();
        locked = 1'b0;
        repeat (3) tick();
        locked = 1'b1;
        tick();
        repeat (8) tick();
        tests++;
        if ({vid_rst_n, core_rst_n} !== 2'b10) begin
            fails++;
            $display("FAIL rel_vid_entry got {vid,core}=%b exp 10", {vid_rst_n, core_rst_n});
        end
        tick();
        rst_n = 1'b0;
        tick();
        tests++;
        if ({pll_rst, mem_rst_n, vid_rst_n, core_rst_n, ready} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_mid_seq got {pll,mem,vid,core,rdy}=%b exp 10000",
                     {pll_rst, mem_rst_n, vid_rst_n, core_rst_n, ready});
        end
        rst_n  = 1'b1;
        locked = 1'b0;
        tick();
        tests++;
        if (pll_rst !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_seq_release pll_rst got %b exp 0", pll_rst);
        end
    endtask

`ifdef PLL_RST_SEQ_RELOCK_EN
    // Pulses after release edge e: pll_rst high for e-9 mod 13 in 0..2, count bumps at 12+13n.
    task automatic test_relock();
        logic exp_p;
        int   exp_r;
        rst_n  = 1'b0;
        locked = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int e = 0; e <= 230; e++) begin
            tick();
            exp_p = (e >= 9) && (((e - 9) % 13) < 3);
            exp_r = (e >= 12) ? ((e - 12) / 13 + 1) : 0;
            if (exp_r > 15) exp_r = 15;
            tests++;
            if (pll_rst !== exp_p) begin
                fails++;
                $display("FAIL relock_pll_rst e=%0d got %b exp %b", e, pll_rst, exp_p);
            end
            tests++;
            if (relock_cnt !== 4'(exp_r)) begin
                fails++;
                $display("FAIL relock_cnt e=%0d got %0d exp %0d", e, relock_cnt, exp_r);
            end
        end
    endtask
`else
    task automatic test_no_relock();
        rst_n  = 1'b0;
        locked = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int e = 0; e <= 40; e++) begin
            tick();
            tests++;
            if ({pll_rst, relock_cnt, mem_rst_n} !== 6'b0_0000_0) begin
                fails++;
                $display("FAIL no_relock e=%0d got pll=%b cnt=%0d mem=%b exp 0 0 0", e,
                         pll_rst, relock_cnt, mem_rst_n);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_release("normal_release");
        test_loss_in_run();
        test_unstable_lock();
        test_reset_in_rel_vid();
`ifdef PLL_RST_SEQ_RELOCK_EN
        test_relock();
`else
        test_no_relock();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
